// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-port external memory bus arbiter.
package mem_bus_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Grant identifiers; also used as the round-robin "last served" marker
    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    // Instruction fetch always moves a whole word
    localparam logic [3:0] BYTE_SEL_WORD = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester external memory bus arbiter: fetch (read-only) and data (r/w).
// One access at a time, fixed wait states, registered glitch-free bus strobes,
// one-cycle ack and held read data per requester.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_byte_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    // external bus
    output logic        ram_ce,
    output logic        bus_re,
    output logic        bus_we,
    output logic [3:0]  bus_byte_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_data_oe,
    input  logic [31:0] bus_rdata
);

    state_t      r_state;
    logic        r_last;
    logic        r_gnt;
    logic [3:0]  r_cnt;
    logic        r_ram_ce;
    logic        r_bus_re;
    logic        r_bus_we;
    logic        r_bus_oe;
    logic [3:0]  r_bus_bs;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_ack;
    logic        r_d_ack;
    logic        w_pick;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last
    assign w_pick = (i_req && d_req) ? ~r_last : (d_req ? GNT_DATA : GNT_FETCH);

    // Arbiter FSM with all bus/ack/rdata outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= GNT_DATA;
            r_gnt       <= GNT_FETCH;
            r_cnt       <= 4'd0;
            r_ram_ce    <= 1'b0;
            r_bus_re    <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_oe    <= 1'b0;
            r_bus_bs    <= 4'd0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_i_rdata   <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_req || d_req) begin
                        r_gnt    <= w_pick;
                        r_last   <= w_pick;
                        r_cnt    <= 4'(WAIT_CYCLES);
                        r_ram_ce <= 1'b1;
                        r_state  <= ACCESS;
                        if (w_pick == GNT_FETCH) begin
                            r_bus_addr  <= i_addr;
                            r_bus_bs    <= BYTE_SEL_WORD;
                            r_bus_wdata <= 32'd0;
                            r_bus_re    <= 1'b1;
                            r_bus_we    <= 1'b0;
                            r_bus_oe    <= 1'b0;
                        end else begin
                            r_bus_addr  <= d_addr;
                            r_bus_bs    <= d_byte_sel;
                            r_bus_wdata <= d_wdata;
                            r_bus_re    <= ~d_we;
                            r_bus_we    <= d_we;
                            r_bus_oe    <= d_we;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        // last wait state: sample read data, release the bus
                        if (!r_bus_we) begin
                            if (r_gnt == GNT_DATA) r_d_rdata <= bus_rdata;
                            else                   r_i_rdata <= bus_rdata;
                        end
                        r_ram_ce    <= 1'b0;
                        r_bus_re    <= 1'b0;
                        r_bus_we    <= 1'b0;
                        r_bus_oe    <= 1'b0;
                        r_bus_bs    <= 4'd0;
                        r_bus_addr  <= 32'd0;
                        r_bus_wdata <= 32'd0;
                        r_i_ack     <= (r_gnt == GNT_FETCH);
                        r_d_ack     <= (r_gnt == GNT_DATA);
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ram_ce       = r_ram_ce;
    assign bus_re       = r_bus_re;
    assign bus_we       = r_bus_we;
    assign bus_data_oe  = r_bus_oe;
    assign bus_byte_sel = r_bus_bs;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign i_rdata      = r_i_rdata;
    assign d_rdata      = r_d_rdata;
    assign i_ack        = r_i_ack;
    assign d_ack        = r_d_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: three instances (WAIT_CYCLES 1, 0, 15)
// each driven by random requesters and checked every cycle against a
// transaction-timing model (start cycle T, strobes T+1..T+1+W, ack T+2+W).
module tb_mem_bus_arbiter;

    localparam int NI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int W = (k == 0) ? 1 : ((k == 1) ? 0 : 15);

        logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
        logic [3:0]  d_bs = 4'd0;
        logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, bus_rdata = '0;
        logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
        logic [3:0]  bus_byte_sel;
        logic        i_ack, d_ack, ram_ce, bus_re, bus_we, bus_data_oe;

        mem_bus_arbiter #(.WAIT_CYCLES(W)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_req       (i_req),
            .i_addr      (i_addr),
            .i_rdata     (i_rdata),
            .i_ack       (i_ack),
            .d_req       (d_req),
            .d_we        (d_we),
            .d_byte_sel  (d_bs),
            .d_addr      (d_addr),
            .d_wdata     (d_wdata),
            .d_rdata     (d_rdata),
            .d_ack       (d_ack),
            .ram_ce      (ram_ce),
            .bus_re      (bus_re),
            .bus_we      (bus_we),
            .bus_byte_sel(bus_byte_sel),
            .bus_addr    (bus_addr),
            .bus_wdata   (bus_wdata),
            .bus_data_oe (bus_data_oe),
            .bus_rdata   (bus_rdata)
        );

        // model state
        bit          m_act = 0, m_g = 0, m_we = 0, m_last = 1;
        int          m_t0 = 0;
        logic [31:0] m_addr = '0, m_wd = '0, m_ri = '0, m_rd = '0;
        logic [3:0]  m_bs = '0;
        bit          ack_i = 0, ack_d = 0;

        // requesters: hold until ack, then drop or immediately issue a new request
        initial forever begin
            @(posedge clk);
            #1;
            bus_rdata = $urandom;
            if (!rst_n) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end else begin
                if (ack_i) i_req = 1'b0;
                if (ack_d) d_req = 1'b0;
                if (!i_req && ($urandom_range(3) != 0)) begin
                    i_req  = 1'b1;
                    i_addr = $urandom;
                end
                if (!d_req && ($urandom_range(3) != 0)) begin
                    d_req   = 1'b1;
                    d_we    = $urandom_range(1);
                    d_bs    = 4'($urandom);
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end
        end

        // per-cycle check against the model, then advance the model
        initial forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_act = 0; m_last = 1; m_ri = '0; m_rd = '0;
                ack_i = 0; ack_d = 0;
                chk($sformatf("w%0d rst ctl", W),
                    {26'd0, ram_ce, bus_re, bus_we, bus_data_oe, i_ack, d_ack}, 32'd0);
                chk($sformatf("w%0d rst bus_addr", W), bus_addr, 32'd0);
                chk($sformatf("w%0d rst i_rdata", W), i_rdata, 32'd0);
                chk($sformatf("w%0d rst d_rdata", W), d_rdata, 32'd0);
            end else begin
                bit strobe, ackc;
                strobe = m_act && (cyc >= m_t0 + 1) && (cyc <= m_t0 + 1 + W);
                ackc   = m_act && (cyc == m_t0 + 2 + W);
                chk($sformatf("w%0d ctl{ce,re,we,oe,iack,dack}", W),
                    {26'd0, ram_ce, bus_re, bus_we, bus_data_oe, i_ack, d_ack},
                    {26'd0, strobe, strobe && !m_we, strobe && m_we, strobe && m_we,
                     ackc && !m_g, ackc && m_g});
                if (strobe) begin
                    chk($sformatf("w%0d bus_addr", W), bus_addr, m_addr);
                    chk($sformatf("w%0d bus_byte_sel", W), {28'd0, bus_byte_sel}, {28'd0, m_bs});
                    if (m_we) chk($sformatf("w%0d bus_wdata", W), bus_wdata, m_wd);
                end
                chk($sformatf("w%0d i_rdata", W), i_rdata, m_ri);
                chk($sformatf("w%0d d_rdata", W), d_rdata, m_rd);
                ack_i = ackc && !m_g;
                ack_d = ackc && m_g;

                if (m_act && (cyc == m_t0 + 1 + W) && !m_we) begin
                    if (m_g) m_rd = bus_rdata;
                    else     m_ri = bus_rdata;
                end
                if (m_act && (cyc == m_t0 + 2 + W)) begin
                    m_act = 0;
                end else if (!m_act && (i_req || d_req)) begin
                    m_g    = (i_req && d_req) ? !m_last : d_req;
                    m_last = m_g;
                    m_act  = 1;
                    m_t0   = cyc;
                    if (m_g) begin
                        m_addr = d_addr; m_we = d_we; m_bs = d_bs; m_wd = d_wdata;
                    end else begin
                        m_addr = i_addr; m_we = 0; m_bs = 4'hF; m_wd = '0;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (1500) @(posedge clk);
        // asynchronous reset in the middle of traffic, then resume
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (1500) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between two requesters: the instruction-fetch port (read-only) and the data port of the memory controller (read/write).
- Grants one requester at a time and holds the bus strobes for a fixed number of wait states.
- Returns read data and a one-cycle ack to the granted requester.
- Sits between the core's memory-side logic and the external bus/RAM pins.

Parameters:
- WAIT_CYCLES, 1, extra bus cycles per access (legal 0..15); the access phase lasts WAIT_CYCLES+1 cycles.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch read request; held until i_ack
- i_addr  in  32  fetch address, stable while i_req
- i_rdata  out  32  fetch read data, valid when i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_byte_sel  in  4  data byte enables
- d_addr  in  32  data address
- d_wdata  in  32  data write value
- d_rdata  out  32  data read data, valid when d_ack
- d_ack  out  1  one-cycle data completion pulse
- ram_ce  out  1  RAM chip enable
- bus_re  out  1  bus read strobe
- bus_we  out  1  bus write strobe
- bus_byte_sel  out  4  bus byte enables
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_data_oe  out  1  drive enable for the bidirectional bus data pins
- bus_rdata  in  32  bus read data

Behaviour:
- Clock and reset: clk with rst_n, asynchronous active-low.
- Reset state:
  - state = IDLE, last_grant = DATA, wait counter = 0.
  - All outputs 0, including i_rdata and d_rdata.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Samples i_req and d_req. If neither is set, stay in IDLE.
  - If exactly one is set, grant that requester.
  - If both are set, grant the requester that is not last_grant (round-robin); update last_grant.
  - On grant, register addr, byte_sel, we and wdata. Fetch uses byte_sel 4'b1111 and we = 0.
  - Load counter = WAIT_CYCLES, then go to ACCESS.
- ACCESS:
  - ram_ce = 1. bus_re = ~we, bus_we = we, bus_data_oe = we.
  - bus_addr, bus_byte_sel and bus_wdata come from the registered values. Outputs are registered, so there are no glitches.
  - Counter decrements each cycle. In the cycle the counter is 0:
    - On a read, capture bus_rdata into the granted requester's rdata register.
    - Go to DONE.
- DONE:
  - All bus strobes 0. Assert the granted requester's ack for exactly one cycle, then go to IDLE.
- Latency: with the request sampled in cycle T, strobes are high in cycles T+1..T+1+WAIT_CYCLES and ack is high in cycle T+2+WAIT_CYCLES. A full access is WAIT_CYCLES+3 cycles, including the IDLE sampling cycle.
- Requester rules:
  - Keep req and its fields stable until ack.
  - Req must be low in the cycle after ack unless a new request is intended. A req seen in IDLE is always treated as a new request.
- rdata registers update only on reads for their own port and hold their value otherwise. d_rdata keeps its old value after a write.
- Requests arriving during ACCESS or DONE are ignored until the next IDLE. The losing requester in a tie is served next with no starvation: at most one foreign access intervenes.
- Reset during ACCESS or DONE aborts immediately: strobes drop asynchronously, no ack is issued and the transaction is lost.
- No address decode and no alignment checking. byte_sel is passed through unchanged.

Decomposition:
- Shared package:
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2
  - grant IDs: GNT_FETCH = 1'b0, GNT_DATA = 1'b1
  - BYTE_SEL_WORD = 4'b1111
- No sub-module needed. The round-robin pick is a few gates and stays inline. The wait counter is inline as well.

Test Plan:
- Single fetch read, WAIT_CYCLES = 1, i_addr = 0x100, bus_rdata = 0xDEADBEEF: bus_re high for 2 cycles with bus_addr = 0x100 and bus_byte_sel = 4'hF; i_ack pulses at T+3 with i_rdata = 0xDEADBEEF; d_ack stays 0.
- Data write, d_addr = 0x2004, d_wdata = 0x12345678, d_byte_sel = 4'b0011: bus_we and bus_data_oe high for WAIT_CYCLES+1 cycles with matching bus fields; d_ack pulses once; d_rdata unchanged.
- Simultaneous i_req and d_req from reset: fetch is served first (last_grant = DATA), then data; d_ack lands exactly WAIT_CYCLES+3 cycles after i_ack. Repeat with both held continuously: grants alternate F, D, F, D.
- WAIT_CYCLES = 0: strobes high exactly 1 cycle and ack at T+2. WAIT_CYCLES = 15: strobes high 16 cycles.
- rst_n asserted mid-ACCESS of a data read: ram_ce, bus_re and d_ack go to 0 immediately; after release the FSM is in IDLE and a re-issued d_req completes normally.
